// File: rtl/seq_detect_pkg.sv
// Shared types and helpers for the parametrised serial pattern detector.
// Detector FSM states, the pattern-length ceiling and the fill-counter width helper.
package seq_detect_pkg;

   typedef enum logic [1:0] {
      EMPTY   = 2'd0,
      FILLING = 2'd1,
      ARMED   = 2'd2
   } seq_state_e;

   localparam int PAT_LEN_MAX = 32;

   // Enough bits to count from 0 up to and including len.
   function automatic int fill_w(input int len);
      return $clog2(len + 1);
   endfunction

endpackage

// File: rtl/seq_match_counter.sv
// Saturating match counter with clear priority and asynchronous reset.
module seq_match_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt_o
);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/seq_detect_param.sv
// Serial bit-pattern detector with runtime-loadable pattern, overlap control and match counter.
// Define SEQ_DETECT_MASK_EN to add a per-bit don't-care mask loaded with the pattern.
module seq_detect_param
   import seq_detect_pkg::*;
#(
   parameter int                 PAT_LEN = 4,
   parameter logic [PAT_LEN-1:0] PAT_RST = PAT_LEN'(4'b0110),
   parameter int                 CNT_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in,
   input  logic               in_valid,
   input  logic               overlap_en,
   input  logic               pat_load,
   input  logic [PAT_LEN-1:0] pat_in,
`ifdef SEQ_DETECT_MASK_EN
   input  logic [PAT_LEN-1:0] pat_mask,
`endif
   input  logic               cnt_clr,
   output logic               y,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               armed
);

   localparam int            FW   = fill_w(PAT_LEN);
   localparam logic [FW-1:0] FULL = FW'(PAT_LEN);

   logic [PAT_LEN-1:0] pat_q, win_q, win_d, win_shift, mask;
   logic [FW-1:0]      fill_q, fill_d, fill_inc;
   seq_state_e         state_q, state_d;
   logic               y_q, accept, match;

`ifdef SEQ_DETECT_MASK_EN
   logic [PAT_LEN-1:0] mask_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mask_q <= '1;
      end else if (pat_load) begin
         mask_q <= pat_mask;
      end
   end

   assign mask = mask_q;
`else
   assign mask = '1;
`endif

   // A load discards any same-cycle bit, so it never feeds the window or a match.
   always_comb begin
      accept    = in_valid && !pat_load;
      win_shift = {win_q[PAT_LEN-2:0], in};
      fill_inc  = (fill_q == FULL) ? FULL : fill_q + 1'b1;
      match     = accept && (((win_shift ^ pat_q) & mask) == '0) && (fill_inc == FULL);

      win_d   = win_q;
      fill_d  = fill_q;
      state_d = state_q;
      if (pat_load) begin
         win_d   = '0;
         fill_d  = '0;
         state_d = EMPTY;
      end else if (accept) begin
         if (match && !overlap_en) begin
            win_d   = '0;
            fill_d  = '0;
            state_d = EMPTY;
         end else begin
            win_d   = win_shift;
            fill_d  = fill_inc;
            state_d = (fill_inc == FULL) ? ARMED : FILLING;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pat_q   <= PAT_RST;
         win_q   <= '0;
         fill_q  <= '0;
         state_q <= EMPTY;
         y_q     <= 1'b0;
      end else begin
         if (pat_load) begin
            pat_q <= pat_in;
         end
         win_q   <= win_d;
         fill_q  <= fill_d;
         state_q <= state_d;
         y_q     <= match;
      end
   end

   seq_match_counter #(
      .CNT_W(CNT_W)
   ) u_cnt (
      .clk  (clk),
      .rst  (rst),
      .inc  (match),
      .clr  (cnt_clr),
      .cnt_o(match_cnt)
   );

   assign y     = y_q;
   assign armed = (state_q == ARMED);

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param: default-width instance plus a 2-bit-counter instance on shared stimulus.
module tb_seq_detect_param;

   logic       clk;
   logic       rst;
   logic       din;
   logic       in_valid;
   logic       overlap_en;
   logic       pat_load;
   logic [3:0] pat_in;
   logic [3:0] pat_mask;
   logic       cnt_clr;
   logic       y, y2;
   logic       armed, armed2;
   logic [7:0] cnt;
   logic [1:0] cnt2;

   int checks = 0;
   int errors = 0;

   seq_detect_param dut (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .in_valid  (in_valid),
      .overlap_en(overlap_en),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
`ifdef SEQ_DETECT_MASK_EN
      .pat_mask  (pat_mask),
`endif
      .cnt_clr   (cnt_clr),
      .y         (y),
      .match_cnt (cnt),
      .armed     (armed)
   );

   seq_detect_param #(.CNT_W(2)) dut_c2 (
      .clk       (clk),
      .rst       (rst),
      .in        (din),
      .in_valid  (in_valid),
      .overlap_en(overlap_en),
      .pat_load  (pat_load),
      .pat_in    (pat_in),
`ifdef SEQ_DETECT_MASK_EN
      .pat_mask  (pat_mask),
`endif
      .cnt_clr   (cnt_clr),
      .y         (y2),
      .match_cnt (cnt2),
      .armed     (armed2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs at the falling edge, then check y just after the rising edge.
   task automatic step(input logic b, input logic v, input logic pl, input logic clr,
                       input logic ey, input string tag);
      @(negedge clk);
      din      = b;
      in_valid = v;
      pat_load = pl;
      cnt_clr  = clr;
      @(posedge clk);
      #1;
      chk(tag, {31'd0, y}, {31'd0, ey});
   endtask

   initial begin
      rst        = 1'b1;
      din        = 1'b0;
      in_valid   = 1'b0;
      overlap_en = 1'b1;
      pat_load   = 1'b0;
      pat_in     = 4'b0000;
      pat_mask   = 4'b1111;
      cnt_clr    = 1'b0;

      // Reset values
      #3;
      chk("rst_y", {31'd0, y}, 32'd0);
      chk("rst_armed", {31'd0, armed}, 32'd0);
      chk("rst_cnt", {24'd0, cnt}, 32'd0);
      chk("rst_cnt2", {30'd0, cnt2}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Overlapping: 0,1,1,0,1,1,0 -> pulses after bits 4 and 7
      overlap_en = 1'b1;
      step(0, 1, 0, 0, 0, "ov_b1");
      step(1, 1, 0, 0, 0, "ov_b2");
      step(1, 1, 0, 0, 0, "ov_b3");
      step(0, 1, 0, 0, 1, "ov_b4");
      chk("ov_armed", {31'd0, armed}, 32'd1);
      step(1, 1, 0, 0, 0, "ov_b5");
      step(1, 1, 0, 0, 0, "ov_b6");
      step(0, 1, 0, 0, 1, "ov_b7");
      chk("ov_cnt", {24'd0, cnt}, 32'd2);
      step(0, 0, 0, 0, 0, "ov_idle");

      // Pattern reload keeps the count; then clear it
      pat_in = 4'b0110;
      step(0, 0, 1, 0, 0, "reload");
      chk("reload_cnt", {24'd0, cnt}, 32'd2);
      chk("reload_armed", {31'd0, armed}, 32'd0);
      step(0, 0, 0, 1, 0, "clr");
      chk("clr_cnt", {24'd0, cnt}, 32'd0);

      // Non-overlapping: only the first match counts
      overlap_en = 1'b0;
      step(0, 1, 0, 0, 0, "nov_b1");
      step(1, 1, 0, 0, 0, "nov_b2");
      step(1, 1, 0, 0, 0, "nov_b3");
      step(0, 1, 0, 0, 1, "nov_b4");
      chk("nov_armed", {31'd0, armed}, 32'd0);
      step(1, 1, 0, 0, 0, "nov_b5");
      step(1, 1, 0, 0, 0, "nov_b6");
      step(0, 1, 0, 0, 0, "nov_b7");
      chk("nov_cnt", {24'd0, cnt}, 32'd1);

      // Valid gap: 0,1,_,1,0
      overlap_en = 1'b1;
      step(0, 0, 1, 0, 0, "gap_load");
      step(0, 0, 0, 1, 0, "gap_clr");
      step(0, 1, 0, 0, 0, "gap_b1");
      step(1, 1, 0, 0, 0, "gap_b2");
      step(1, 0, 0, 0, 0, "gap_hole");
      step(1, 1, 0, 0, 0, "gap_b3");
      step(0, 1, 0, 0, 1, "gap_b4");
      chk("gap_cnt", {24'd0, cnt}, 32'd1);

      // Load 1001 alongside a valid bit; the bit is dropped
      pat_in = 4'b1001;
      step(1, 1, 1, 1, 0, "ld_cycle");
      chk("ld_cnt", {24'd0, cnt}, 32'd0);
      step(1, 1, 0, 0, 0, "ld_b1");
      step(0, 1, 0, 0, 0, "ld_b2");
      step(0, 1, 0, 0, 0, "ld_b3");
      step(1, 1, 0, 0, 1, "ld_b4");
      chk("ld_match_cnt", {24'd0, cnt}, 32'd1);
      step(1, 1, 1, 0, 0, "ld2_cycle");
      step(0, 1, 0, 0, 0, "ld2_b1");
      step(0, 1, 0, 0, 0, "ld2_b2");
      step(1, 1, 0, 0, 0, "ld2_b3");
      chk("ld2_cnt", {24'd0, cnt}, 32'd1);

      // Saturation of the 2-bit counter, then clear beating a match
      pat_in = 4'b0110;
      step(0, 0, 1, 1, 0, "sat_load");
      chk("sat_cnt2_start", {30'd0, cnt2}, 32'd0);
      step(0, 1, 0, 0, 0, "sat_m1a");
      step(1, 1, 0, 0, 0, "sat_m1b");
      step(1, 1, 0, 0, 0, "sat_m1c");
      step(0, 1, 0, 0, 1, "sat_m1d");
      for (int m = 2; m <= 5; m++) begin
         step(1, 1, 0, 0, 0, "sat_ma");
         step(1, 1, 0, 0, 0, "sat_mb");
         step(0, 1, 0, 0, 1, "sat_mc");
         if (m >= 3) begin
            chk("sat_cnt2", {30'd0, cnt2}, 32'd3);
         end
      end
      chk("sat_cnt", {24'd0, cnt}, 32'd5);
      step(1, 1, 0, 0, 0, "sat_m6a");
      step(1, 1, 0, 0, 0, "sat_m6b");
      step(0, 1, 0, 1, 1, "sat_m6_clr");
      chk("clr_win_cnt", {24'd0, cnt}, 32'd0);
      chk("clr_win_cnt2", {30'd0, cnt2}, 32'd0);

      // Asynchronous reset between edges
      step(1, 1, 0, 0, 0, "ar_a");
      step(1, 1, 0, 0, 0, "ar_b");
      step(0, 1, 0, 0, 1, "ar_match");
      chk("ar_pre_cnt", {24'd0, cnt}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("ar_y", {31'd0, y}, 32'd0);
      chk("ar_armed", {31'd0, armed}, 32'd0);
      chk("ar_cnt", {24'd0, cnt}, 32'd0);
      chk("ar_cnt2", {30'd0, cnt2}, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Reset after 0,1,1: the next 0110 needs all four bits
      step(0, 1, 0, 0, 0, "ar2_b1");
      step(1, 1, 0, 0, 0, "ar2_b2");
      step(1, 1, 0, 0, 0, "ar2_b3");
      #2;
      rst = 1'b1;
      #1;
      chk("ar2_armed", {31'd0, armed}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      step(0, 1, 0, 0, 0, "ar3_b1");
      step(1, 1, 0, 0, 0, "ar3_b2");
      step(1, 1, 0, 0, 0, "ar3_b3");
      step(0, 1, 0, 0, 1, "ar3_b4");
      chk("ar3_cnt", {24'd0, cnt}, 32'd1);
      step(0, 0, 0, 0, 0, "final_idle");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised serial bit-pattern detector; successor to the fixed 4-bit "0110" detector.
- Pattern length is a parameter; the pattern is runtime-loadable.
- Supports overlapping and non-overlapping match modes, qualifies input bits with a valid strobe, and keeps a saturating match counter.
- Sits on a serial bit stream in the control path; `y` drives downstream event logic, `match_cnt` feeds status readback.

Parameters:
- PAT_LEN, 4, pattern length in bits (2..32).
- PAT_RST, 4'b0110 (width PAT_LEN), pattern value after reset.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit.
- in_valid  input  1  `in` is sampled only when high.
- overlap_en  input  1  1 = overlapping matches, 0 = non-overlapping; sampled every cycle.
- pat_load  input  1  load `pat_in` into the pattern register.
- pat_in  input  PAT_LEN  new pattern, MSB = first bit received.
- cnt_clr  input  1  synchronous clear of `match_cnt`.
- y  output  1  registered one-cycle match pulse.
- match_cnt  output  CNT_W  saturating count of matches.
- armed  output  1  high when the window holds PAT_LEN valid bits.

Behaviour:
- Reset (async, `rst`=1):
  - pattern = PAT_RST, window = 0, fill = 0, state = EMPTY.
  - `y` = 0, `match_cnt` = 0, `armed` = 0.
- Window register:
  - PAT_LEN-bit shift register. On an accepted bit, window <= {window[PAT_LEN-2:0], in}.
  - Bits shift in at the LSB; the oldest bit sits at the MSB and is compared against pattern MSB.
- fill counter:
  - Width $clog2(PAT_LEN+1).
  - Increments on each accepted bit and saturates at PAT_LEN.
- State machine:
  - EMPTY (fill = 0) -> FILLING on an accepted bit.
  - FILLING -> ARMED when fill reaches PAT_LEN.
  - ARMED -> EMPTY on a match when overlap_en = 0.
  - Any state -> EMPTY on pat_load.
- `armed` = (state == ARMED), registered.
- Match condition, evaluated at an edge:
  - in_valid = 1, the post-shift window equals the pattern, and the post-increment fill = PAT_LEN.
  - On a match, `y` = 1 for exactly the next cycle (latency: 1 cycle after the edge that samples the completing bit).
  - Otherwise `y` = 0.
- Non-overlap mode (overlap_en = 0):
  - On a match, fill is cleared and the window is zeroed.
  - The next match needs PAT_LEN fresh bits.
- Overlap mode:
  - fill stays at PAT_LEN, so a match is possible on every accepted bit.
- in_valid = 0:
  - window, fill and state hold; `y` <= 0.
- pat_load:
  - pattern <= pat_in, window <= 0, fill <= 0, `y` <= 0.
  - Takes priority over a same-cycle in_valid; that bit is discarded and not counted.
- match_cnt:
  - Increments by 1 per match and saturates at 2^CNT_W-1 (no wrap).
  - cnt_clr wins over a same-cycle match: result is 0.
  - pat_load does not clear `match_cnt`.
- overlap_en toggled while ARMED: the new value applies from the next match decision; no retroactive effect.
- Reset asserted mid-stream: all state returns to reset values immediately, independent of `clk`.

Optional Feature:
- Macro: SEQ_DETECT_MASK_EN.
- Defined:
  - Adds input port `pat_mask [PAT_LEN-1:0]`, loaded alongside `pat_in` on pat_load; reset value all-ones.
  - Bit positions with mask = 0 are don't-care in the comparison.
- Undefined:
  - No port; all bits are compared (equivalent to mask all-ones).

Decomposition:
- Package `seq_detect_pkg`:
  - State enum `seq_state_e` {EMPTY, FILLING, ARMED}, 2 bits.
  - Localparam PAT_LEN_MAX = 32.
  - Helper function `fill_w(len)` returning $clog2(len+1).
- One sub-module, `seq_match_counter`, parametrised by CNT_W:
  - Inputs: inc, clr.
  - Behaviour: saturating, clear-priority counter with async reset.
- Pattern register, window, fill and FSM stay in the top module.

Test Plan:
- Reset with defaults, overlap_en = 1, stream 0,1,1,0,1,1,0 all valid -> `y` pulses after bits 4 and 7; match_cnt = 2.
- Same stream with overlap_en = 0 -> single `y` pulse after bit 4; match_cnt = 1; `armed` drops the cycle after the match.
- Stream 0,1,_,1,0 with in_valid = 0 on the gap cycle -> one match; `y` does not fire during the gap; match_cnt = 1.
- pat_load with pat_in = 4'b1001 on the same cycle as valid bit 1, then stream 1,0,0,1 -> the loaded bit is ignored; a match is reported after the fourth subsequent bit.
- CNT_W = 2, 5 overlapping matches of 0110 -> match_cnt stays at 3; cnt_clr coincident with the sixth match -> match_cnt = 0.
- Assert `rst` asynchronously between edges after the input 0,1,1 -> `y`, `armed` and `match_cnt` go to 0 at once; the next "0110" needs all 4 bits.
